capture_dma_ctrl: RTL and testbench
===================================

Name: capture_dma_ctrl

Overview:
- Sequences one packet capture per software start command.
- Reads the packet words at word addresses pkt_begin..pkt_end from the on-chip packet RAM (fixed 1-cycle read latency).
- Writes them through an Avalon-MM master into the SDRAM capture ring buffer [capt_buf_start, capt_buf_start+capt_buf_size).
- Sits between the driver register bank (consumes its out_* configuration) and SDRAM; returns state, busy, done, capt_buf_wrap, processing_cc and last_write_addr to the bank's status inputs.

Parameters:
N, 32, data width and address width for both the packet RAM and SDRAM.
START_BIT, 2, bit of the control register that commands a capture start.
CLEAR_BIT, 3, bit of the control register that resets the ring write pointer and the wrap flag.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
control  in  N  control register contents; only START_BIT and CLEAR_BIT are used
pkt_begin  in  N  first packet RAM word address
pkt_end  in  N  last packet RAM word address (inclusive)
capt_buf_start  in  N  ring base byte address, 4-byte aligned
capt_buf_size  in  N  ring size in bytes; low 2 bits ignored
src_address  out  N  packet RAM word address
src_read  out  1  packet RAM read strobe
src_readdata  in  N  packet RAM data, valid the cycle after src_read
avm_address  out  N  SDRAM byte address
avm_write  out  1  SDRAM write request
avm_writedata  out  N  SDRAM write data
avm_waitrequest  in  1  SDRAM stall
state  out  2  0=IDLE, 1=READ, 2=WRITE, 3=DONE
busy  out  1  high in READ and WRITE
done  out  1  sticky: last capture finished
capt_buf_wrap  out  1  sticky: ring pointer has wrapped
processing_cc  out  N  cycles taken by the last capture
last_write_addr  out  N  byte address of the last accepted SDRAM write

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; all outputs 0; wr_ptr=capt_buf_start.
- Start detect: start = control[START_BIT] high this cycle and low the previous cycle (registered edge detect). The edge-detect register also updates while busy.
- Start acceptance: start is accepted only in IDLE or DONE; a start while busy is ignored.
- On accept:
  - latch pkt_begin, pkt_end, capt_buf_start, capt_buf_size;
  - rd_ptr=pkt_begin; done=0; processing_cc=0.
  - If pkt_end<pkt_begin, or size[N-1:2]==0: go directly to DONE, no SDRAM writes.
  - Otherwise go to READ.
- Clear: control[CLEAR_BIT] high in IDLE or DONE sets wr_ptr=capt_buf_start and capt_buf_wrap=0. Clear is ignored while busy. If clear and start occur in the same cycle, clear applies first.
- READ:
  - cycle 1: src_read=1, src_address=rd_ptr;
  - cycle 2: src_read=0; capture src_readdata into wdata; go to WRITE.
  - Minimum latency per word is 3 cycles: 2 in READ plus 1 in WRITE with no stall.
- WRITE:
  - avm_write=1, avm_address=wr_ptr, avm_writedata=wdata.
  - Address and data are held stable while avm_waitrequest=1.
  - On accept (avm_write & !avm_waitrequest): last_write_addr=wr_ptr; advance wr_ptr.
  - Then go to DONE if rd_ptr==pkt_end_latched; otherwise rd_ptr+1 and go to READ.
- Ring arithmetic:
  - end = base + (size & ~3).
  - If wr_ptr+4==end: wr_ptr=base and capt_buf_wrap=1.
  - Otherwise wr_ptr+=4.
  - All sums are modulo 2^N.
  - wr_ptr persists across captures until reset or clear.
- processing_cc:
  - increments every cycle in READ and WRITE, stall cycles included;
  - saturates at all-ones;
  - holds its value in DONE and IDLE.
- DONE: done=1, busy=0. Stays in DONE until the next accepted start, then goes directly to READ or DONE; it does not pass through IDLE.
- Reset mid-transfer: avm_write and src_read are 0 from the next edge; no partial state survives.

Decomposition:
- Package capture_pkg holds:
  - typedef enum logic [1:0] capt_state_t {IDLE, READ, WRITE, DONE};
  - constants START_BIT_DEF and CLEAR_BIT_DEF.
- Sub-module ring_ptr handles wr_ptr advance, the wrap flag and clear. It is instantiated once.

Test Plan:
- Basic: base=0x1000, size=0x100, pkt 4..7, no stalls, start pulse -> 4 writes to 0x1000, 0x1004, 0x1008, 0x100C with RAM words 4..7; last_write_addr=0x100C; processing_cc=12; done=1; wrap=0.
- Wrap: size=0x10, two captures of 3 words each -> second capture writes 0x100C, then 0x1000, 0x1004; capt_buf_wrap=1; last_write_addr=0x1004.
- Stall: avm_waitrequest high for 5 cycles on the 2nd write -> address and data held stable; exactly 4 accepts; processing_cc=17.
- Degenerate: pkt_end=2, pkt_begin=5 -> DONE next cycle; zero avm_write; done=1. Separately, size=3 -> same result.
- Start while busy and held level: control[START_BIT] held high through the capture -> only one capture runs. Clear asserted while busy -> ignored; wr_ptr continues.
- Reset mid-WRITE with waitrequest=1 -> next cycle state=0, avm_write=0, all status outputs 0; a new start then writes from capt_buf_start.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and default control-register bit positions for the packet capture sequencer.
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } capt_state_t;

   localparam int unsigned START_BIT_DEF = 2;
   localparam int unsigned CLEAR_BIT_DEF = 3;

endpackage

// File: rtl/ring_ptr.sv
// SDRAM ring-buffer write pointer: advances by one word per accepted write and wraps to the
// ring base, raising a sticky wrap flag; clear and reset reload it from the live base address.
module ring_ptr #(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] init_base,
   input  logic         clear,
   input  logic         advance,
   input  logic [N-1:0] ring_base,
   input  logic [N-1:0] ring_size,
   output logic [N-1:0] wr_ptr,
   output logic         wrap
);

   logic [N-1:0] wr_ptr_q, wr_ptr_d;
   logic [N-1:0] ring_end, next_ptr;
   logic         wrap_q, wrap_d;

   always_comb begin
      ring_end = ring_base + (ring_size & {{(N-2){1'b1}}, 2'b00});
      next_ptr = wr_ptr_q + N'(4);
      wr_ptr_d = wr_ptr_q;
      wrap_d   = wrap_q;
      if (clear) begin
         wr_ptr_d = init_base;
         wrap_d   = 1'b0;
      end else if (advance) begin
         if (next_ptr == ring_end) begin
            wr_ptr_d = ring_base;
            wrap_d   = 1'b1;
         end else begin
            wr_ptr_d = next_ptr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= init_base;
         wrap_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         wrap_q   <= wrap_d;
      end
   end

   assign wr_ptr = wr_ptr_q;
   assign wrap   = wrap_q;

endmodule

// File: rtl/capture_dma_ctrl.sv
// Capture DMA sequencer: copies packet RAM words pkt_begin..pkt_end into an SDRAM ring buffer
// through an Avalon-MM master, one capture per rising edge of the start control bit.
module capture_dma_ctrl
   import capture_pkg::*;
#(
   parameter int unsigned N         = 32,
   parameter int unsigned START_BIT = START_BIT_DEF,
   parameter int unsigned CLEAR_BIT = CLEAR_BIT_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] control,
   input  logic [N-1:0] pkt_begin,
   input  logic [N-1:0] pkt_end,
   input  logic [N-1:0] capt_buf_start,
   input  logic [N-1:0] capt_buf_size,
   output logic [N-1:0] src_address,
   output logic         src_read,
   input  logic [N-1:0] src_readdata,
   output logic [N-1:0] avm_address,
   output logic         avm_write,
   output logic [N-1:0] avm_writedata,
   input  logic         avm_waitrequest,
   output logic [1:0]   state,
   output logic         busy,
   output logic         done,
   output logic         capt_buf_wrap,
   output logic [N-1:0] processing_cc,
   output logic [N-1:0] last_write_addr
);

   capt_state_t  state_q, state_d;
   logic         rd_phase_q, rd_phase_d;
   logic         start_prev_q;
   logic [N-1:0] rd_ptr_q, rd_ptr_d, end_q, end_d;
   logic [N-1:0] base_q, base_d, size_q, size_d;
   logic [N-1:0] wdata_q, wdata_d, cc_q, cc_d, lwa_q, lwa_d;
   logic [N-1:0] wr_ptr;
   logic         start, idle_or_done, accept, degenerate, wr_accept, ring_clear;
   logic         unused_control;

   assign unused_control = ^control;

   always_comb begin
      start        = control[START_BIT] & ~start_prev_q;
      idle_or_done = (state_q == IDLE) || (state_q == DONE);
      accept       = start & idle_or_done;
      ring_clear   = control[CLEAR_BIT] & idle_or_done;
      degenerate   = (pkt_end < pkt_begin) || (capt_buf_size[N-1:2] == '0);
      wr_accept    = (state_q == WRITE) & ~avm_waitrequest;
   end

   always_comb begin
      state_d    = state_q;
      rd_phase_d = rd_phase_q;
      rd_ptr_d   = rd_ptr_q;
      end_d      = end_q;
      base_d     = base_q;
      size_d     = size_q;
      wdata_d    = wdata_q;
      cc_d       = cc_q;
      lwa_d      = lwa_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               rd_ptr_d   = pkt_begin;
               end_d      = pkt_end;
               base_d     = capt_buf_start;
               size_d     = capt_buf_size;
               cc_d       = '0;
               rd_phase_d = 1'b0;
               state_d    = degenerate ? DONE : READ;
            end
         end
         READ: begin
            // Phase 0 issues the read; phase 1 catches the data one cycle later.
            if (!rd_phase_q) begin
               rd_phase_d = 1'b1;
            end else begin
               rd_phase_d = 1'b0;
               wdata_d    = src_readdata;
               state_d    = WRITE;
            end
         end
         WRITE: begin
            if (wr_accept) begin
               lwa_d = wr_ptr;
               if (rd_ptr_q == end_q) begin
                  state_d = DONE;
               end else begin
                  rd_ptr_d = rd_ptr_q + N'(1);
                  state_d  = READ;
               end
            end
         end
      endcase
      if (busy && (cc_q != '1)) begin
         cc_d = cc_q + N'(1);
      end
   end

   ring_ptr #(
      .N (N)
   ) u_ring_ptr (
      .clk       (clk),
      .reset     (reset),
      .init_base (capt_buf_start),
      .clear     (ring_clear),
      .advance   (wr_accept),
      .ring_base (base_q),
      .ring_size (size_q),
      .wr_ptr    (wr_ptr),
      .wrap      (capt_buf_wrap)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         rd_phase_q   <= 1'b0;
         start_prev_q <= 1'b0;
         rd_ptr_q     <= '0;
         end_q        <= '0;
         base_q       <= '0;
         size_q       <= '0;
         wdata_q      <= '0;
         cc_q         <= '0;
         lwa_q        <= '0;
      end else begin
         state_q      <= state_d;
         rd_phase_q   <= rd_phase_d;
         start_prev_q <= control[START_BIT];
         rd_ptr_q     <= rd_ptr_d;
         end_q        <= end_d;
         base_q       <= base_d;
         size_q       <= size_d;
         wdata_q      <= wdata_d;
         cc_q         <= cc_d;
         lwa_q        <= lwa_d;
      end
   end

   // Bus outputs are gated to zero outside their phase so idle and reset look clean.
   always_comb begin
      state           = state_q;
      busy            = (state_q == READ) || (state_q == WRITE);
      done            = (state_q == DONE);
      src_read        = (state_q == READ) && !rd_phase_q;
      src_address     = src_read ? rd_ptr_q : '0;
      avm_write       = (state_q == WRITE);
      avm_address     = avm_write ? wr_ptr : '0;
      avm_writedata   = avm_write ? wdata_q : '0;
      processing_cc   = cc_q;
      last_write_addr = lwa_q;
   end

endmodule

// File: tb/tb_capture_dma_ctrl.sv
// Randomized self-checking bench for capture_dma_ctrl with a behavioural packet RAM and a
// word-list reference model of the SDRAM ring writes.
module tb_capture_dma_ctrl;

   localparam int START_BIT = 2;
   localparam int CLEAR_BIT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] control, pkt_begin, pkt_end, capt_buf_start, capt_buf_size;
   logic [31:0] src_address, src_readdata, avm_address, avm_writedata;
   logic [31:0] processing_cc, last_write_addr;
   logic        src_read, avm_write, avm_waitrequest, busy, done, capt_buf_wrap;
   logic [1:0]  state;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          total_acc = 0;
   logic [31:0] m_wr, m_lwa, m_cc;
   logic        m_wrap;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   always #5 clk = ~clk;

   capture_dma_ctrl u_dut (
      .clk             (clk),
      .reset           (reset),
      .control         (control),
      .pkt_begin       (pkt_begin),
      .pkt_end         (pkt_end),
      .capt_buf_start  (capt_buf_start),
      .capt_buf_size   (capt_buf_size),
      .src_address     (src_address),
      .src_read        (src_read),
      .src_readdata    (src_readdata),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .state           (state),
      .busy            (busy),
      .done            (done),
      .capt_buf_wrap   (capt_buf_wrap),
      .processing_cc   (processing_cc),
      .last_write_addr (last_write_addr)
   );

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
   endfunction

   // Packet RAM with one-cycle latency; garbage when not read exposes mistimed captures.
   always @(posedge clk) src_readdata <= src_read ? ram_word(src_address) : $urandom;

   always @(negedge clk) if (avm_write && !avm_waitrequest) total_acc++;

   task automatic do_capture(input logic [31:0] pb, input logic [31:0] pe,
                             input logic [31:0] base, input logic [31:0] size,
                             input int stall_idx, input int stall_len, input bit rand_stall,
                             input bit hold_start, input bit clr_with_start,
                             input int clr_busy_at, output int ncyc);
      int          nwords = 0, n_stall = 0, n_fixed = 0, idx = 0, unstable = 0;
      bit          was_stalled = 1'b0, done_seen = 1'b0, wreq;
      logic [31:0] st_addr = '0, st_data = '0, lim, ea, ed;
      ncyc = -1;
      @(posedge clk); #1;
      pkt_begin = pb; pkt_end = pe; capt_buf_start = base; capt_buf_size = size;
      control[START_BIT] = 1'b1;
      control[CLEAR_BIT] = clr_with_start;
      exp_addr.delete(); exp_data.delete();
      if (clr_with_start) begin m_wr = base; m_wrap = 1'b0; end
      if (pe >= pb && size[31:2] != 30'd0) begin
         lim    = base + (size & 32'hFFFF_FFFC);
         nwords = int'(pe - pb) + 1;
         for (int k = 0; k < nwords; k++) begin
            exp_addr.push_back(m_wr);
            exp_data.push_back(ram_word(pb + 32'(k)));
            m_lwa = m_wr;
            if (m_wr + 32'd4 == lim) begin m_wr = base; m_wrap = 1'b1; end
            else m_wr = m_wr + 32'd4;
         end
      end
      @(posedge clk); #1;
      control[CLEAR_BIT] = 1'b0;
      if (!hold_start) control[START_BIT] = 1'b0;
      for (int c = 0; c < 400; c++) begin
         wreq = 1'b0;
         if (avm_write) begin
            if (idx == stall_idx && n_fixed < stall_len) begin wreq = 1'b1; n_fixed++; end
            else if (rand_stall && $urandom_range(0, 2) == 0) wreq = 1'b1;
         end
         if (wreq) n_stall++;
         avm_waitrequest    = wreq;
         control[CLEAR_BIT] = (c == clr_busy_at) && busy;
         @(negedge clk);
         if (avm_write) begin
            if (was_stalled && (avm_address !== st_addr || avm_writedata !== st_data))
               unstable++;
            if (!avm_waitrequest) begin
               was_stalled = 1'b0;
               idx++;
               if (exp_addr.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL extra_write: got write to %h, want no write", avm_address);
               end else begin
                  ea = exp_addr.pop_front();
                  ed = exp_data.pop_front();
                  n_cmp += 2;
                  if (avm_address !== ea) begin
                     n_fail++;
                     $display("FAIL write_addr: got %h, want %h", avm_address, ea);
                  end
                  if (avm_writedata !== ed) begin
                     n_fail++;
                     $display("FAIL write_data: got %h, want %h", avm_writedata, ed);
                  end
               end
            end else begin
               was_stalled = 1'b1;
               st_addr     = avm_address;
               st_data     = avm_writedata;
            end
         end
         if (state == 2'd3) begin done_seen = 1'b1; ncyc = c; break; end
         @(posedge clk); #1;
      end
      avm_waitrequest = 1'b0;
      n_cmp++;
      if (!done_seen) begin
         n_fail++;
         $display("FAIL timeout: got state %0d after 400 cycles, want 3", state);
      end
      n_cmp++;
      if (exp_addr.size() != 0) begin
         n_fail++;
         $display("FAIL missing_writes: got %0d outstanding, want 0", exp_addr.size());
      end
      n_cmp++;
      if (unstable != 0) begin
         n_fail++;
         $display("FAIL stall_hold: got %0d changes under waitrequest, want 0", unstable);
      end
      m_cc = 32'(3 * nwords + n_stall);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({state, busy, done, capt_buf_wrap, avm_write, src_read} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, want 0", {state, busy, done, capt_buf_wrap,
                  avm_write, src_read});
      end
      n_cmp++;
      if ({processing_cc, last_write_addr} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_status: got cc %h lwa %h, want 0 0", processing_cc,
                  last_write_addr);
      end
      n_cmp++;
      if ({avm_address, src_address, avm_writedata} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_bus: got %h %h %h, want 0", avm_address, src_address,
                  avm_writedata);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      m_wr = capt_buf_start; m_wrap = 1'b0; m_lwa = '0; m_cc = '0;
   endtask

   task automatic test_basic();
      int ncyc;
      do_capture(32'd4, 32'd7, 32'h1000, 32'h100, -1, 0, 1'b0, 1'b0, 1'b0, -1, ncyc);
      n_cmp++;
      if (last_write_addr !== 32'h100C) begin
         n_fail++; $display("FAIL basic_lwa: got %h, want 0000100c", last_write_addr);
      end
      n_cmp++;
      if (processing_cc !== 32'd12) begin
         n_fail++; $display("FAIL basic_cc: got %0d, want 12", processing_cc);
      end
      n_cmp++;
      if ({done, busy, capt_buf_wrap} !== 3'b100) begin
         n_fail++; $display("FAIL basic_flags: got %b, want 100", {done, busy, capt_buf_wrap});
      end
   endtask

   task automatic test_wrap();
      int ncyc;
      do_capture(32'd0, 32'd2, 32'h1000, 32'h10, -1, 0, 1'b0, 1'b0, 1'b1, -1, ncyc);
      do_capture(32'd10, 32'd12, 32'h1000, 32'h10, -1, 0, 1'b0, 1'b0, 1'b0, -1, ncyc);
      n_cmp++;
      if (capt_buf_wrap !== 1'b1) begin
         n_fail++; $display("FAIL wrap_flag: got %b, want 1", capt_buf_wrap);
      end
      n_cmp++;
      if (last_write_addr !== 32'h1004) begin
         n_fail++; $display("FAIL wrap_lwa: got %h, want 00001004", last_write_addr);
      end
   endtask

   task automatic test_stall();
      int ncyc;
      do_capture(32'd4, 32'd7, 32'h1000, 32'h100, 1, 5, 1'b0, 1'b0, 1'b1, -1, ncyc);
      n_cmp++;
      if (processing_cc !== 32'd17) begin
         n_fail++; $display("FAIL stall_cc: got %0d, want 17", processing_cc);
      end
      n_cmp++;
      if (last_write_addr !== 32'h100C) begin
         n_fail++; $display("FAIL stall_lwa: got %h, want 0000100c", last_write_addr);
      end
   endtask

   task automatic test_degenerate();
      int ncyc;
      int acc0;
      for (int t = 0; t < 2; t++) begin
         acc0 = total_acc;
         if (t == 0) do_capture(32'd5, 32'd2, 32'h1000, 32'h100, -1, 0, 1'b0, 1'b0, 1'b0, -1,
                                ncyc);
         else        do_capture(32'd4, 32'd7, 32'h1000, 32'h3, -1, 0, 1'b0, 1'b0, 1'b0, -1,
                                ncyc);
         n_cmp++;
         if (ncyc !== 0) begin
            n_fail++; $display("FAIL degen_latency[%0d]: got %0d cycles, want 0", t, ncyc);
         end
         n_cmp++;
         if (total_acc !== acc0) begin
            n_fail++; $display("FAIL degen_writes[%0d]: got %0d, want 0", t, total_acc - acc0);
         end
         n_cmp++;
         if ({done, processing_cc} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL degen_status[%0d]: got done %b cc %0d, want 1 0", t, done,
                     processing_cc);
         end
         n_cmp++;
         if (last_write_addr !== m_lwa) begin
            n_fail++;
            $display("FAIL degen_lwa[%0d]: got %h, want %h", t, last_write_addr, m_lwa);
         end
         // A real one-word capture between the two so cc is non-zero before the second.
         if (t == 0) do_capture(32'd9, 32'd9, 32'h1000, 32'h100, -1, 0, 1'b0, 1'b0, 1'b0, -1,
                                ncyc);
      end
   endtask

   task automatic test_start_held();
      int ncyc;
      int acc0;
      do_capture(32'd20, 32'd24, 32'h1000, 32'h100, -1, 0, 1'b0, 1'b1, 1'b0, 2, ncyc);
      acc0 = total_acc;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (state !== 2'd3 || total_acc !== acc0) begin
         n_fail++;
         $display("FAIL held_start: got state %0d extra writes %0d, want 3 0", state,
                  total_acc - acc0);
      end
      n_cmp++;
      if (processing_cc !== m_cc) begin
         n_fail++; $display("FAIL held_cc: got %0d, want %0d", processing_cc, m_cc);
      end
      @(posedge clk); #1;
      control[START_BIT] = 1'b0;
      do_capture(32'd30, 32'd31, 32'h1000, 32'h100, -1, 0, 1'b0, 1'b0, 1'b0, -1, ncyc);
      n_cmp++;
      if (last_write_addr !== m_lwa) begin
         n_fail++; $display("FAIL busy_clear_lwa: got %h, want %h", last_write_addr, m_lwa);
      end
   endtask

   task automatic test_random();
      int          ncyc;
      logic [31:0] base, size, pb, pe;
      base = 32'h4000 + 32'(4 * $urandom_range(0, 255));
      for (int it = 0; it < 8; it++) begin
         size = 32'($urandom_range(0, 64));
         pb   = 32'($urandom_range(1, 200));
         pe   = pb + 32'($urandom_range(0, 6)) - 32'd1;
         do_capture(pb, pe, base, size, -1, 0, 1'b1, 1'b0,
                    (it == 0) || ($urandom_range(0, 2) == 0), -1, ncyc);
         n_cmp++;
         if ({last_write_addr, processing_cc} !== {m_lwa, m_cc}) begin
            n_fail++;
            $display("FAIL rand_status[%0d]: got lwa %h cc %0d, want %h %0d", it,
                     last_write_addr, processing_cc, m_lwa, m_cc);
         end
         n_cmp++;
         if ({done, capt_buf_wrap} !== {1'b1, m_wrap}) begin
            n_fail++;
            $display("FAIL rand_flags[%0d]: got %b, want %b", it, {done, capt_buf_wrap},
                     {1'b1, m_wrap});
         end
      end
   endtask

   task automatic test_reset_mid_write();
      int ncyc;
      bit seen = 1'b0;
      @(posedge clk); #1;
      capt_buf_start = 32'h2000; capt_buf_size = 32'h40; pkt_begin = 32'd1; pkt_end = 32'd4;
      avm_waitrequest    = 1'b1;
      control[START_BIT] = 1'b1;
      @(posedge clk); #1;
      control[START_BIT] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (avm_write) begin seen = 1'b1; break; end
      end
      n_cmp++;
      if (!seen) begin
         n_fail++; $display("FAIL midrst_reach_write: got avm_write 0 for 20 cycles, want 1");
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({state, avm_write, src_read, busy, done, capt_buf_wrap} !== 7'd0) begin
         n_fail++;
         $display("FAIL midrst_ctrl: got %b, want 0", {state, avm_write, src_read, busy, done,
                  capt_buf_wrap});
      end
      n_cmp++;
      if ({processing_cc, last_write_addr} !== 64'd0) begin
         n_fail++;
         $display("FAIL midrst_status: got cc %h lwa %h, want 0 0", processing_cc,
                  last_write_addr);
      end
      @(posedge clk); #1;
      reset = 1'b1; avm_waitrequest = 1'b0;
      m_wr = 32'h2000; m_wrap = 1'b0; m_lwa = '0; m_cc = '0;
      do_capture(32'd1, 32'd4, 32'h2000, 32'h40, -1, 0, 1'b0, 1'b0, 1'b0, -1, ncyc);
      n_cmp++;
      if (last_write_addr !== 32'h200C) begin
         n_fail++; $display("FAIL midrst_restart_lwa: got %h, want 0000200c", last_write_addr);
      end
   endtask

   initial begin
      reset = 1'b0; control = '0; pkt_begin = '0; pkt_end = '0;
      capt_buf_start = 32'h1000; capt_buf_size = 32'h100; avm_waitrequest = 1'b0;
      m_wr = '0; m_wrap = 1'b0; m_lwa = '0; m_cc = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_degenerate();
      test_start_held();
      test_random();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
